// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// operation codes, FSM state encodings and operation decode helpers.
package ex_mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first,
// results settle WIDTH cycles after start.
module mdu_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   shifted_c;
  logic             borrow_c;
  logic [WIDTH-1:0] rem_sub_c;

  // Trial subtraction; the true difference always fits WIDTH bits when there is no borrow
  always_comb begin
    shifted_c = {rem_q, quo_q[WIDTH-1]};
    borrow_c  = shifted_c < {1'b0, dvs_q};
    rem_sub_c = shifted_c[WIDTH-1:0] - dvs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (borrow_c) begin
        rem_q <= shifted_c[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q <= rem_sub_c;
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multi-cycle multiply/divide unit producing a HI/LO pair with a
// one-cycle done pulse; stalls the pipeline while busy, abortable by flush.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id2_mdu_valid,
  input  logic [1:0]       id2_mdu_op,
  input  logic [WIDTH-1:0] id2_rs_data,
  input  logic [WIDTH-1:0] id2_rt_data,
  input  logic             ex_flush,
  output logic             ex_stall_req,
  output logic             ex_mdu_done,
  output logic [1:0]       ex_w_hilo_ena,
  output logic [WIDTH-1:0] ex_hi_res,
  output logic [WIDTH-1:0] ex_lo_res
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH;

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              capture_c, done_c;
  mdu_op_e           op_c;

  logic [WIDTH-1:0]  a_q, b_q;
  logic              div_q, sgn_q, neg_quo_q, neg_rem_q, zero_q;
  logic [PROD_W-1:0] prod_q, prod_c, ext_a_c, ext_b_c;
  logic [WIDTH-1:0]  out_hi_q, out_lo_q, fin_hi_c, fin_lo_c;
  logic [WIDTH-1:0]  mag_a_c, mag_b_c, quo_c, rem_c;
  logic              div_signed_c;

  assign op_c = mdu_op_e'(id2_mdu_op);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; flush overrides capture and the done pulse
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_c = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (id2_mdu_valid) begin
          capture_c = 1'b1;
          if (op_is_div(op_c)) begin
            state_d = ST_DIV;
            cnt_d   = CNT_W'(WIDTH - 1);
          end else begin
            state_d = ST_MUL;
            cnt_d   = CNT_W'(MUL_LAT - 1);
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ex_flush) begin
      state_d   = ST_IDLE;
      capture_c = 1'b0;
      done_c    = 1'b0;
    end
    ex_stall_req  = id2_mdu_valid & (state_q != ST_DONE) & ~ex_flush;
    ex_mdu_done   = done_c;
    ex_w_hilo_ena = {2{done_c}};
  end

  // Divider sees magnitudes; signs are reapplied on the way out
  always_comb begin
    div_signed_c = (op_c == MDU_DIV);
    mag_a_c = (div_signed_c && id2_rs_data[WIDTH-1]) ? -id2_rs_data : id2_rs_data;
    mag_b_c = (div_signed_c && id2_rt_data[WIDTH-1]) ? -id2_rt_data : id2_rt_data;
  end

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (capture_c & op_is_div(op_c)),
    .dividend  (mag_a_c),
    .divisor   (mag_b_c),
    .quotient  (quo_c),
    .remainder (rem_c)
  );

  always_comb begin
    ext_a_c = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b_c = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod_c  = ext_a_c * ext_b_c;
  end

  always_comb begin
    if (!div_q) begin
      fin_hi_c = prod_q[PROD_W-1:WIDTH];
      fin_lo_c = prod_q[WIDTH-1:0];
    end else if (zero_q) begin
      fin_hi_c = a_q;
      fin_lo_c = '1;
    end else begin
      fin_hi_c = neg_rem_q ? -rem_c : rem_c;
      fin_lo_c = neg_quo_q ? -quo_c : quo_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      div_q     <= 1'b0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      prod_q    <= '0;
      out_hi_q  <= '0;
      out_lo_q  <= '0;
    end else begin
      if (capture_c) begin
        a_q       <= id2_rs_data;
        b_q       <= id2_rt_data;
        div_q     <= op_is_div(op_c);
        sgn_q     <= op_is_signed(op_c);
        neg_quo_q <= div_signed_c & (id2_rs_data[WIDTH-1] ^ id2_rt_data[WIDTH-1]);
        neg_rem_q <= div_signed_c & id2_rs_data[WIDTH-1];
        zero_q    <= (id2_rt_data == '0);
      end
      if (state_q == ST_MUL && cnt_q == '0) prod_q <= prod_c;
      if (done_c) begin
        out_hi_q <= fin_hi_c;
        out_lo_q <= fin_lo_c;
      end
    end
  end

  assign ex_hi_res = done_c ? fin_hi_c : out_hi_q;
  assign ex_lo_res = done_c ? fin_lo_c : out_lo_q;

endmodule
